// File: rtl/uart_tx_ctrl.sv
// UART transmit control: frames a byte as start, LSB-first data, optional parity and stop.
// It drives the external serializer's shift enable and registers the serial line.
module uart_tx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic                  busy,
    output logic                  TX_OUT
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e state_q, state_d;
    logic   tx_q, tx_d;
    logic   par_bit_q, par_bit_d;
    logic   par_en_q, par_en_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        tx_d      = 1'b1;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                // Parity comes from P_DATA now; the serializer loads the same byte at this edge.
                if (Data_Valid) begin
                    state_d   = START;
                    par_bit_d = PAR_TYP ? ~(^P_DATA) : (^P_DATA);
                    par_en_d  = PAR_EN;
                end
            end
            START: begin
                tx_d    = 1'b0;
                state_d = DATA;
            end
            DATA: begin
                tx_d = ser_data;
                if (ser_done) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                tx_d    = par_bit_q;
                state_d = STOP;
            end
            STOP: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign ser_en = (state_q == DATA);
    assign TX_OUT = tx_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl with a behavioural serializer and frame-level reference model.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       ser_done;
  logic       ser_data;
  logic       ser_en;
  logic       busy;
  logic       TX_OUT;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .ser_done   (ser_done),
    .ser_data   (ser_data),
    .ser_en     (ser_en),
    .busy       (busy),
    .TX_OUT     (TX_OUT)
  );

  always #5 CLK = ~CLK;

  // Behavioural 8-bit serializer: loads when idle, shifts LSB first, done on the 8th bit.
  logic [7:0] ser_sh;
  logic [2:0] ser_cnt;
  logic       junk_done;
  logic       junk_data;

  always @(posedge CLK) begin
    if (RST) begin
      ser_cnt <= 3'd0;
    end else if (!busy && Data_Valid) begin
      ser_sh  <= P_DATA;
      ser_cnt <= 3'd0;
    end else if (ser_en) begin
      ser_cnt <= ser_cnt + 3'd1;
    end
  end

  // Outside DATA the serializer lines carry noise that the controller must ignore.
  assign ser_data = ser_en ? ser_sh[ser_cnt] : junk_data;
  assign ser_done = ser_en ? (ser_cnt == 3'd7) : junk_done;

  typedef struct packed {
    logic tx;
    logic bsy;
    logic en;
  } exp_t;

  exp_t exp_q[$];
  int   busy_left = 0;
  int   vectors   = 0;
  int   fails     = 0;
  int   cyc       = 0;
  bit   mon_on    = 1'b0;

  function automatic exp_t mk(input logic tx, input logic bsy, input logic en);
    exp_t e;
    e.tx  = tx;
    e.bsy = bsy;
    e.en  = en;
    return e;
  endfunction

  // Reference: an accepted frame predicts the cycle-by-cycle line/busy/ser_en pattern
  // (line lags the frame by one cycle), followed by idle (line high, not busy).
  always @(posedge CLK) begin
    cyc++;
    if (RST) begin
      exp_q.delete();
      busy_left = 0;
    end else if (busy_left == 0) begin
      if (Data_Valid) begin
        logic [7:0] d;
        logic       par;
        d   = P_DATA;
        par = PAR_TYP ? ~(^d) : (^d);
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b1, 1'b1));
        for (int unsigned i = 0; i < 7; i++) exp_q.push_back(mk(d[i], 1'b1, 1'b1));
        exp_q.push_back(mk(d[7], 1'b1, 1'b0));
        if (PAR_EN) exp_q.push_back(mk(par, 1'b1, 1'b0));
        busy_left = PAR_EN ? 11 : 10;
      end
    end else begin
      busy_left--;
    end
  end

  exp_t mon_e;
  always @(negedge CLK) begin
    if (mon_on) begin
      if (exp_q.size() > 0) mon_e = exp_q.pop_front();
      else                  mon_e = mk(1'b1, 1'b0, 1'b0);
      vectors++;
      if ({TX_OUT, busy, ser_en} !== {mon_e.tx, mon_e.bsy, mon_e.en}) begin
        fails++;
        $display("FAIL line_state cycle %0d: tx/busy/ser_en got %b%b%b expected %b%b%b",
                 cyc, TX_OUT, busy, ser_en, mon_e.tx, mon_e.bsy, mon_e.en);
      end
    end
  end

  task automatic check(input bit ok, input string what);
    vectors++;
    if (!ok) begin
      fails++;
      $display("FAIL %s cycle %0d: tx/busy/ser_en = %b%b%b", what, cyc, TX_OUT, busy, ser_en);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    junk_done = 1'($urandom);
    junk_data = 1'($urandom);
  endtask

  task automatic wait_idle(input int unsigned max_cycles, input string what);
    int unsigned n;
    n = 0;
    while (busy === 1'b1 && n < max_cycles) begin
      step();
      n++;
    end
    check(busy === 1'b0, what);
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt);
    Data_Valid = 1'b1;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    step();
    Data_Valid = 1'b0;
    repeat (14) begin
      P_DATA  = 8'($urandom);
      PAR_EN  = 1'($urandom);
      PAR_TYP = 1'($urandom);
      step();
    end
    wait_idle(20, "frame_timeout");
  endtask

  initial begin
    RST        = 1'b1;
    P_DATA     = 8'h00;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    junk_done  = 1'b0;
    junk_data  = 1'b0;
    step();
    mon_on = 1'b1;
    repeat (2) step();
    RST = 1'b0;
    repeat (20) begin
      step();
      check(TX_OUT === 1'b1 && busy === 1'b0 && ser_en === 1'b0, "reset_idle");
    end

    send(8'hA5, 1'b1, 1'b0);
    send(8'h01, 1'b1, 1'b1);
    send(8'h03, 1'b1, 1'b1);
    send(8'hFF, 1'b0, 1'b0);

    // Data_Valid held high: back-to-back frames, mid-frame changes must not leak in.
    Data_Valid = 1'b1;
    P_DATA     = 8'h55;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b0;
    step();
    P_DATA = 8'h0F;
    repeat (20) begin
      PAR_TYP = ~PAR_TYP;
      step();
    end
    Data_Valid = 1'b0;
    repeat (14) step();
    wait_idle(20, "b2b_timeout");

    // Reset in the middle of DATA, then a clean frame.
    Data_Valid = 1'b1;
    P_DATA     = 8'($urandom);
    PAR_EN     = 1'b1;
    step();
    Data_Valid = 1'b0;
    repeat (4) step();
    RST = 1'b1;
    step();
    check(TX_OUT === 1'b1 && busy === 1'b0 && ser_en === 1'b0, "mid_frame_reset");
    RST = 1'b0;
    repeat (3) step();
    send(8'hC3, 1'b1, 1'b1);

    repeat (400) begin
      Data_Valid = ($urandom_range(0, 3) == 0);
      P_DATA     = 8'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
      RST        = ($urandom_range(0, 99) == 0);
      step();
    end
    RST        = 1'b0;
    Data_Valid = 1'b0;
    repeat (15) step();
    wait_idle(20, "final_timeout");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Transmit-side control stage of the UART Tx path. Drives the serializer's `ser_en`, receives its `ser_done`/`ser_data`, computes the optional parity bit, and produces the registered serial line `TX_OUT`. It frames each byte as start bit, 8 data bits LSB first, optional parity, and stop bit. It sits between the host-side `P_DATA`/`Data_Valid` source and the pad, wrapped around the serializer.

## Interface
- `DATA_WIDTH`, 8, data bits per frame; must match the serializer width (3-bit counter, `ser_done` at count 7).
- `CLK` in 1: Tx bit clock; one bit per cycle.
- `RST` in 1: synchronous, active-high reset.
- `P_DATA` in 8: parallel byte; sampled only for parity, in the accept cycle.
- `Data_Valid` in 1: request to send `P_DATA`.
- `PAR_EN` in 1: 1 inserts a parity bit; latched at accept.
- `PAR_TYP` in 1: 0 = even, 1 = odd; latched at accept.
- `ser_done` in 1: from serializer; high in the cycle the last data bit is on `ser_data`.
- `ser_data` in 1: from serializer; current data bit.
- `ser_en` out 1: serializer shift enable.
- `busy` out 1: frame in progress; also gates the serializer load.
- `TX_OUT` out 1: serial line, registered, idle high.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Held in a state register.
- `busy` = (state != IDLE), decoded combinationally from the state register. `ser_en` = (state == DATA).
- Accept: in IDLE with `Data_Valid`=1 at the clock edge:
  - go to START;
  - latch parity bit: even = XOR of `P_DATA`; odd = its inverse;
  - latch `PAR_EN`.
  - The serializer loads `P_DATA` at the same edge, because `busy`=0.
- START: 1 cycle, then DATA.
- DATA: stay until `ser_done`=1. Then go to PARITY if latched `PAR_EN`=1, else STOP.
- PARITY: 1 cycle, then STOP. STOP: 1 cycle, then IDLE.
- Line mux, registered: `TX_OUT` <= 1 in IDLE/STOP, 0 in START, `ser_data` in DATA, latched parity in PARITY.
- `Data_Valid` while `busy`=1 is ignored; there is no queue. Changes to `P_DATA`, `PAR_EN` or `PAR_TYP` mid-frame have no effect on the current frame.
- Reset (any state, mid-frame included): next cycle state=IDLE, `TX_OUT`=1, `busy`=0, `ser_en`=0, latched parity=0, latched `PAR_EN`=0. The serializer is reset alongside by the system.

## Timing
- Let c0 be the cycle whose edge samples `Data_Valid`=1 in IDLE.
- c1: START, `busy`=1.
- c2–c9: DATA, `ser_en`=1; `ser_done`=1 in c9.
- c10: PARITY (if enabled). c11: STOP. c12: IDLE, `busy`=0.
- `TX_OUT` lags state by 1 cycle:
  - start bit during c2;
  - bit0..bit7 during c3–c10;
  - parity during c11;
  - stop during c12.
- Without parity, every step from PARITY onward is one cycle earlier: STOP in c10, IDLE in c11.
- Next accept is possible at the end of c12 (c11 without parity). The IDLE cycle gives at least one extra high bit between back-to-back frames.
- `ser_done` seen in any state other than DATA is ignored.

## Test plan
- Reset, then hold `Data_Valid`=0 for 20 cycles: `TX_OUT`=1, `busy`=0, `ser_en`=0 throughout.
- `P_DATA`=0xA5, `PAR_EN`=1, `PAR_TYP`=0, one-cycle `Data_Valid`:
  - `TX_OUT` from c2 reads 0,1,0,1,0,0,1,0,1,0(parity),1;
  - `busy` high c1–c11, `ser_en` high c2–c9.
- `P_DATA`=0x01, `PAR_EN`=1, `PAR_TYP`=1: parity bit = 0. Repeat with 0x03 and `PAR_TYP`=1: parity bit = 1.
- `PAR_EN`=0, `P_DATA`=0xFF: 10-bit frame 0,1×8,1; `busy` falls in c11.
- `Data_Valid` held high continuously with 0x55 then 0x0F: two frames separated by exactly one IDLE cycle. The pulse in mid-frame is ignored. `PAR_TYP` toggled mid-frame does not alter the parity.
- Assert `RST` during DATA (c5): next cycle `TX_OUT`=1, `busy`=0, `ser_en`=0. A new `Data_Valid` after release produces a clean full frame.
